// File: rtl/mult_issue_stage_pkg.sv
// mult_issue_stage_pkg: shared widths and sign/magnitude helpers for the multiply issue stage
package mult_issue_stage_pkg;
  localparam int W  = 32;
  localparam int PW = 2 * W;
  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
    return (s && x[W-1]) ? -x : x;
  endfunction
  function automatic logic [PW-1:0] cneg(input logic [PW-1:0] x, input logic n);
    return n ? -x : x;
  endfunction
endpackage

// File: rtl/wallace32.sv
// wallace32: combinational 32x32 unsigned multiplier built from a carry-save (Wallace) reduction tree
module wallace32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  logic [63:0] r [33];
  logic [63:0] t [22];
  // partial products, eight levels of 3:2 compression (32->22->15->10->7->5->4->3->2), final add
  always_comb begin
    for (int i = 0; i < 32; i++) r[i] = b[i] ? (64'(a) << i) : '0;
    r[32] = '0;
    for (int l = 0; l < 8; l++) begin
      for (int g = 0; g < 11; g++) begin
        t[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
        t[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2])) << 1;
      end
      for (int i = 0; i < 22; i++) r[i] = t[i];
      for (int i = 22; i < 33; i++) r[i] = '0;
    end
    p = r[0] + r[1];
  end
endmodule

// File: rtl/mult_issue_stage.sv
// mult_issue_stage: two-stage signed/unsigned multiply wrapper with valid/ready on both sides
module mult_issue_stage
  import mult_issue_stage_pkg::*;
#(
  parameter int WIDTH = W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             out_ovf
);
  logic          advance;
  logic          s1_valid, s1_neg, s1_signed, s2_valid, ovf;
  logic [W-1:0]  s1_mag_a, s1_mag_b;
  logic [PW-1:0] core_prod, prod;
  wallace32 u_core (
    .a (s1_mag_a),
    .b (s1_mag_b),
    .p (core_prod)
  );
  // whole pipe moves unless a result is waiting on a stalled consumer; sign is restored after the core
  always_comb begin
    advance   = !s2_valid || out_ready;
    in_ready  = advance;
    out_valid = s2_valid;
    prod      = cneg(core_prod, s1_neg);
    ovf       = s1_signed ? (prod[PW-1:W] != {W{prod[W-1]}}) : (prod[PW-1:W] != '0);
  end
  // stage-1 occupancy; reset drops anything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) s1_valid <= 1'b0;
    else if (advance) s1_valid <= in_valid;
  end
  // stage-1 operands as magnitudes plus result sign, captured only on an accepted input
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_mag_a  <= mag(in_a, in_signed);
      s1_mag_b  <= mag(in_b, in_signed);
      s1_neg    <= in_signed && (in_a[W-1] ^ in_b[W-1]);
      s1_signed <= in_signed;
    end
  end
  // stage-2 result register feeding the outputs directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      out_hi   <= '0;
      out_lo   <= '0;
      out_ovf  <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_hi  <= prod[PW-1:W];
        out_lo  <= prod[W-1:0];
        out_ovf <= ovf;
      end
    end
  end
endmodule
